gf256_inv_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `gf256_inv` iterative inverter among `N_REQ` Reed-Solomon decoder clients, e.g. Forney error-magnitude and syndrome/locator normalisation. It selects a requester, latches its operand, pulses the inverter start and waits out its fixed latency. It then returns the inverse with a one-cycle acknowledge to the granted client. It owns all handshake state, so clients never touch the inverter directly.

---
 rtl/gf256_inv_arb.sv | 162 ++++++++++++++++
 tb/tb_gf256_inv_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gf256_inv_arb.sv
`default_nettype none
// ============================================================================
// Module   : gf256_inv_arb (with internal gf256_inv)
// Brief    : Round-robin arbiter sharing one iterative GF(2^8) inverter
//            (poly 0x11D) among N_REQ Reed-Solomon decoder clients.
// Revision : 1.0 - initial release
// ============================================================================

module gf256_inv (
    input  logic       i_clk,
    input  logic       i_start,
    input  logic [7:0] x,
    output logic [7:0] y,
    output logic       o_ready
);

    logic [7:0] r_sq;
    logic [7:0] r_acc;
    logic [2:0] r_cnt;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // x^-1 = x^254 = x^2 * x^4 * ... * x^128: seven square-and-multiply steps
    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_sq  <= gf_mul(x, x);
            r_acc <= 8'h01;
            r_cnt <= 3'd7;
        end else if (r_cnt != 3'd0) begin
            r_acc <= gf_mul(r_acc, r_sq);
            r_sq  <= gf_mul(r_sq, r_sq);
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign y       = r_acc;
    assign o_ready = (r_cnt == 3'd0);

endmodule

module gf256_inv_arb #(
    parameter int N_REQ = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [8*N_REQ-1:0]       i_x,
    output logic [N_REQ-1:0]         o_ack,
    output logic [7:0]               o_y,
    output logic [$clog2(N_REQ)-1:0] o_grant,
    output logic                     o_busy
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [GW-1:0]      r_last;
    logic [GW-1:0]      r_grant;
    logic [7:0]         r_opnd;
    logic [7:0]         r_y;
    logic [N_REQ-1:0]   r_ack;
    logic               r_busy;
    logic               r_start;

    logic               w_found;
    logic [GW-1:0]      w_win;
    logic [7:0]         w_inv_y;
    logic               w_inv_ready;
    int                 w_idx;

    // First requester found scanning upward from last+1, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(r_last) + i) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_last  <= GW'(N_REQ - 1);
            r_grant <= '0;
            r_opnd  <= 8'h00;
            r_y     <= 8'h00;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_grant <= w_win;
                        r_opnd  <= i_x[8*int'(w_win) +: 8];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_start <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // o_ready is only trusted here, after our own LAUNCH reloaded the counter
                    if (w_inv_ready) begin
                        r_y     <= w_inv_y;
                        r_ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    gf256_inv u_inv (
        .i_clk   (i_clk),
        .i_start (r_start),
        .x       (r_opnd),
        .y       (w_inv_y),
        .o_ready (w_inv_ready)
    );

    assign o_ack   = r_ack;
    assign o_y     = r_y;
    assign o_grant = r_grant;
    assign o_busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_gf256_inv_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf256_inv_arb
// Brief    : Directed scoreboard bench for gf256_inv_arb (N_REQ = 4).
// Revision : 1.0 - initial release
// ============================================================================

module tb_gf256_inv_arb;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   i_req;
    logic [8*N-1:0] i_x;
    logic [N-1:0]   o_ack;
    logic [7:0]     o_y;
    logic [1:0]     o_grant;
    logic           o_busy;

    typedef struct {
        int         cl;
        logic [7:0] y;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ncyc  = 0;
    bit   prev_ack = 0;

    gf256_inv_arb #(.N_REQ(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (i_req),
        .i_x     (i_x),
        .o_ack   (o_ack),
        .o_y     (o_y),
        .o_grant (o_grant),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    // Brute-force search: independent of any exponentiation scheme
    function automatic logic [7:0] ref_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 1; b < 256; b++)
            if (ref_mul(a, 8'(b)) == 8'h01) r = 8'(b);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (prev_ack) check("busy_after_done", 32'(o_busy), 32'd0);
        prev_ack = (o_ack != '0);
        if (o_ack !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(o_ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_onehot", 32'(o_ack), 32'd1 << e.cl);
                check("grant", 32'(o_grant), 32'(e.cl));
                check("y", 32'(o_y), 32'(e.y));
                check("busy_in_done", 32'(o_busy), 32'd1);
                if (e.cyc >= 0) check("latency", 32'(ncyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic request(input int cl, input logic [7:0] x);
        i_x[8*cl +: 8] = x;
        i_req[cl] = 1'b1;
        sb.push_back('{cl, ref_inv(x), ncyc + 10});
    endtask

    task automatic wait_ack(input int cl, input bit drop);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if (o_ack[cl] === 1'b1) got = 1'b1;
        end
        check("ack_timeout", 32'(got), 32'd1);
        if (drop) i_req[cl] = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        i_req = '0;
        i_x   = '0;
        tick();
        tick();
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_y", 32'(o_y), 32'd0);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        tick();

        // single client 0, 0x02 -> 0x8E
        check("model_inv02", 32'(ref_inv(8'h02)), 32'h8E);
        request(0, 8'h02);
        wait_ack(0, 1'b1);
        tick();

        // edge operands on client 1
        request(1, 8'h01);
        wait_ack(1, 1'b1);
        tick();
        request(1, 8'h00);
        wait_ack(1, 1'b1);
        tick();
        request(1, 8'h8E);
        wait_ack(1, 1'b1);
        tick();

        // operand changes one cycle after grant
        request(1, 8'h10);
        tick();
        i_x[15:8] = 8'h77;
        wait_ack(1, 1'b1);
        tick();

        // reset during WAIT: aborted grant never acks, request reserved afterwards
        request(1, 8'h35);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_ack", 32'(o_ack), 32'd0);
        check("midrst_y", 32'(o_y), 32'd0);
        check("midrst_grant", 32'(o_grant), 32'd0);
        void'(sb.pop_back());
        tick();
        tick();
        rst = 1'b0;
        sb.push_back('{1, ref_inv(8'h35), ncyc + 10});
        wait_ack(1, 1'b1);
        tick();

        // all four held from reset
        rst = 1'b1;
        i_x = {8'h05, 8'h04, 8'h03, 8'h02};
        i_req = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++)
            sb.push_back('{c, ref_inv(i_x[8*c +: 8]), ncyc + 10 + 11*c});
        for (int c = 0; c < 4; c++) wait_ack(c, 1'b1);
        tick();

        // client 2 holds, client 3 requests once: 2, 3, 2
        i_x[23:16] = 8'h53;
        i_x[31:24] = 8'hCA;
        i_req[2] = 1'b1;
        i_req[3] = 1'b1;
        sb.push_back('{2, ref_inv(8'h53), ncyc + 10});
        sb.push_back('{3, ref_inv(8'hCA), ncyc + 21});
        sb.push_back('{2, ref_inv(8'h53), ncyc + 32});
        wait_ack(2, 1'b0);
        wait_ack(3, 1'b1);
        wait_ack(2, 1'b1);
        repeat (3) tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
